stochastic_stream_gen: RTL and testbench

//  Binary-to-stochastic converter; the transmit end of the unipolar bitstream link whose receive end is the

---
 rtl/sc_pkg.sv | 9 +
 rtl/sc_lfsr.sv | 19 +
 rtl/stochastic_stream_gen.sv | 65 ++++++
 tb/tb_stochastic_stream_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared types and LFSR tap table for the stochastic bitstream link.
package sc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  // Maximal-length feedback masks, bit k-1 set for tap k, widths 4..16
  localparam logic [15:0] LFSR_TAPS [4:16] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hD008
  };
endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: Fibonacci LFSR; value shows SEED while load is high so the first bit of a window uses it.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int W = 8,
  parameter int SEED = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] value
);
  localparam logic [W-1:0] TAPS = LFSR_TAPS[W][W-1:0];
  logic [W-1:0] state_q, state_d;
  assign value = load ? W'(SEED) : state_q;
  always_comb state_d = (load || step) ? {value[W-2:0], ^(value & TAPS)} : state_q;
  always_ff @(posedge clk) state_q <= reset ? W'(SEED) : state_d;
endmodule

// File: rtl/stochastic_stream_gen.sv
// stochastic_stream_gen: turns each accepted word into a 2^W-1 bit unipolar window holding exactly that many ones.
module stochastic_stream_gen
  import sc_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int MODE = 0,
  parameter int LFSR_SEED = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [VALUE_WIDTH-1:0] in_value,
  output logic                   in_ready,
  output logic                   bit_out,
  output logic                   frame_start,
  output logic                   busy
);
  localparam int W = VALUE_WIDTH;
  localparam logic [W-1:0] LAST = '1;
  state_t state_q, state_d;
  logic [W-1:0] cur_q, cur_d, pend_q, pend_d, cnt_q, cnt_d, val, idx, lfsr_val;
  logic pend_v_q, pend_v_d, bit_q, bit_d, fs_q, fs_d, acc, last, start, step;
  assign in_ready = (state_q == IDLE) || (state_q == RUN && !pend_v_q);
  assign bit_out = bit_q;
  assign frame_start = fs_q;
  assign busy = state_q != IDLE;
  sc_lfsr #(.W(W), .SEED(LFSR_SEED)) u_lfsr (
    .clk(clk), .reset(reset), .load(start), .step(step), .value(lfsr_val)
  );
  // cnt_q counts bits already emitted; a window starts with the word at hand or the pending one
  always_comb begin
    acc = in_valid && in_ready;
    last = state_q == RUN && cnt_q == LAST;
    start = (state_q == IDLE && acc) || (last && (pend_v_q || acc));
    step = state_q == RUN && !last;
    val = start ? (pend_v_q ? pend_q : in_value) : cur_q;
    idx = start ? '0 : cnt_q;
    bit_d = (start || step) && ((MODE != 0) ? (idx < val) : (lfsr_val <= val));
    fs_d = start || last;
    cur_d = val;
    cnt_d = (start || step) ? idx + 1'b1 : cnt_q;
    pend_v_d = !start && (acc || pend_v_q);
    pend_d = (acc && !start) ? in_value : pend_q;
    state_d = start ? RUN : last ? FLUSH : (state_q == FLUSH) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      cnt_q <= '0;
      bit_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      fs_q <= fs_d;
    end
  end
endmodule

// File: tb/tb_stochastic_stream_gen.sv
// tb_stochastic_stream_gen: scoreboard bench; an accumulator model closes each window and compares its ones count.
module tb_stochastic_stream_gen;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [7:0] in_value = '0;
  logic rdy0, bit0, fs0, busy0, rdy1, bit1, fs1, busy1;
  int checks = 0, failures = 0, cyc = 0;
  int q0[$], q1[$], fs_log[$];
  int ones[2], len[2], act[2], brk[2], last_brk[2], zseen[2];
  bit mon_en = 0;
  int w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  stochastic_stream_gen #(.VALUE_WIDTH(8), .MODE(0), .LFSR_SEED(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_value(in_value),
    .in_ready(rdy0), .bit_out(bit0), .frame_start(fs0), .busy(busy0));
  stochastic_stream_gen #(.VALUE_WIDTH(8), .MODE(1), .LFSR_SEED(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_value(in_value),
    .in_ready(rdy1), .bit_out(bit1), .frame_start(fs1), .busy(busy1));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, output int waited);
    waited = 0;
    in_valid = 1;
    in_value = 8'(v);
    while (!rdy0 && waited < 1000) begin
      step();
      waited++;
    end
    if (rdy0) begin
      q0.push_back(v);
      q1.push_back(v);
      step();
    end else check("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy0 && n < 2000) begin
      step();
      n++;
    end
    check("idle_timeout", busy0, 0);
  endtask

  task automatic mon(input int d, input logic b, input logic f);
    int e, rem;
    if (f) begin
      if (d == 0) fs_log.push_back(cyc);
      if (act[d] != 0) begin
        rem = (d == 0) ? q0.size() : q1.size();
        if (rem == 0) check($sformatf("sb_empty%0d", d), 0, 1);
        else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("acc_out%0d", d), ones[d], e);
          check($sformatf("win_len%0d", d), len[d], 255);
          if (d == 1) check("ones_first", brk[d], 0);
          last_brk[d] = brk[d];
        end
      end
      rem = (d == 0) ? q0.size() : q1.size();
      if (rem == 0) begin
        if (act[d] == 0) check($sformatf("spurious_fs%0d", d), 1, 0);
        else check($sformatf("flush_bit%0d", d), int'(b), 0);
      end
      act[d] = (rem > 0) ? 1 : 0;
      ones[d] = int'(b);
      len[d] = 1;
      zseen[d] = b ? 0 : 1;
      brk[d] = 0;
    end else if (act[d] != 0) begin
      ones[d] += int'(b);
      len[d]++;
      if (b && zseen[d] != 0) brk[d] = 1;
      if (!b) zseen[d] = 1;
    end else if (b) check($sformatf("idle_bit%0d", d), int'(b), 0);
  endtask

  always @(negedge clk) if (mon_en) begin
    mon(0, bit0, fs0);
    mon(1, bit1, fs1);
  end

  initial begin
    repeat (2) step();
    check("rst_bit", bit0, 0);
    check("rst_fs", fs0, 0);
    check("rst_busy", busy0, 0);
    check("rst_rdy", rdy0, 1);
    reset = 0;
    mon_en = 1;
    // word 0: frame at T+1, flush at T+256, idle at T+257
    send(0, w);
    check("t1_fs_first", fs0, 1);
    check("t1_busy", busy0, 1);
    for (int i = 0; i < 255; i++) begin
      if (i < 254 && fs0 && i > 0) check("t1_fs_mid", fs0, 0);
      step();
    end
    check("t1_flush_fs", fs0, 1);
    check("t1_flush_bit", bit0, 0);
    check("t1_flush_rdy", rdy0, 0);
    step();
    check("t1_idle", busy0, 0);
    send(255, w);
    wait_idle();
    send(100, w);
    wait_idle();
    check("t3_mode0_scattered", last_brk[0], 1);
    // back-to-back with the second word offered mid-window
    fs_log.delete();
    send(37, w);
    repeat (100) step();
    send(200, w);
    check("t4_pend_wait", w, 0);
    wait_idle();
    check("t4_fs_count", fs_log.size(), 3);
    if (fs_log.size() == 3) begin
      check("t4_second_fs", fs_log[1] - fs_log[0], 255);
      check("t4_flush_fs", fs_log[2] - fs_log[0], 510);
    end
    // source holds words while pending is full
    send(10, w);
    send(20, w);
    send(30, w);
    check("t5_hold30", int'(w > 200), 1);
    send(40, w);
    check("t5_hold40", int'(w > 200), 1);
    wait_idle();
    // reset mid-window with a pending word
    send(123, w);
    repeat (48) step();
    send(77, w);
    mon_en = 0;
    reset = 1;
    step();
    check("t6_bit", int'(bit0 | bit1), 0);
    check("t6_fs", int'(fs0 | fs1), 0);
    check("t6_busy", int'(busy0 | busy1), 0);
    reset = 0;
    q0.delete();
    q1.delete();
    act = '{0, 0};
    mon_en = 1;
    step();
    check("t6_no_fs", int'(fs0 | fs1), 0);
    check("t6_still_idle", busy0, 0);
    send(60, w);
    wait_idle();
    for (int i = 0; i < 3; i++) send($urandom_range(0, 255), w);
    wait_idle();
    repeat (3) step();
    check("sb_drained0", q0.size(), 0);
    check("sb_drained1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
